// File: rtl/pipeline_id_tracker_if.sv
// ---------------------------------------------------------------------------
// pipeline_id_tracker_if
//   Groups the tracker's control inputs and per-stage observation outputs.
//   master : pipeline side (CPU or testbench). It drives stall/flush/hlt and
//            reads the stage and counter view.
//   slave  : the tracker itself.
//
//   stall, flush, hlt            pipeline control, sampled on posedge clk
//   <stg>_valid / <stg>_id       live bit and sequence ID per stage (IF..WB)
//   wb_stall_cnt                 stall cycles accumulated by the WB instruction
//   retired_count/squashed_count wrapping event counters
//   done                         sticky, set once the HLT instruction has retired
// ---------------------------------------------------------------------------
interface pipeline_id_tracker_if #(
    parameter int ID_W    = 7,
    parameter int STALL_W = 4
);
    logic               stall;
    logic               flush;
    logic               hlt;

    logic               if_valid;
    logic               id_valid;
    logic               ex_valid;
    logic               mem_valid;
    logic               wb_valid;
    logic [ID_W-1:0]    if_id;
    logic [ID_W-1:0]    id_id;
    logic [ID_W-1:0]    ex_id;
    logic [ID_W-1:0]    mem_id;
    logic [ID_W-1:0]    wb_id;
    logic [STALL_W-1:0] wb_stall_cnt;
    logic [31:0]        retired_count;
    logic [15:0]        squashed_count;
    logic               done;

    modport master (
        output stall, flush, hlt,
        input  if_valid, id_valid, ex_valid, mem_valid, wb_valid,
        input  if_id, id_id, ex_id, mem_id, wb_id,
        input  wb_stall_cnt, retired_count, squashed_count, done
    );

    modport slave (
        input  stall, flush, hlt,
        output if_valid, id_valid, ex_valid, mem_valid, wb_valid,
        output if_id, id_id, ex_id, mem_id, wb_id,
        output wb_stall_cnt, retired_count, squashed_count, done
    );
endinterface

// File: rtl/pipeline_id_tracker.sv
// ---------------------------------------------------------------------------
// pipeline_id_tracker
//   Shadows the five-stage CPU pipeline. Every fetched instruction gets a
//   sequence ID (0..DEPTH-1, wrapping). The ID, a valid bit and a saturating
//   stall count travel IF->ID->EX->MEM->WB under the CPU's stall, flush and
//   halt rules. Retired and squashed instructions are counted, and done is
//   set once the HLT instruction leaves WB.
//
//   Ports
//     clk   sole clock, everything updates on posedge
//     rst   synchronous active-high reset
//     bus   pipeline_id_tracker_if.slave (controls in, stage view out)
//
//   All outputs come straight from flops, so there is no combinational path
//   from any input to any output.
//   Requirement on parameters: 2**ID_W >= DEPTH.
// ---------------------------------------------------------------------------
module pipeline_id_tracker #(
    parameter int DEPTH   = 72,
    parameter int ID_W    = 7,
    parameter int STALL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_id_tracker_if.slave  bus
);

    localparam int NSTG  = 5;
    localparam int S_IF  = 0;
    localparam int S_ID  = 1;
    localparam int S_EX  = 2;
    localparam int S_MEM = 3;
    localparam int S_WB  = 4;

    // Contents of one pipeline stage. A bubble is all zeros, so consumers
    // must qualify id with valid.
    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    id;
        logic [STALL_W-1:0] stall;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t [NSTG-1:0]  stg_q, stg_d;
    logic [ID_W-1:0]    next_id_q, next_id_d;
    logic               halt_seen_q, halt_seen_d;
    logic [ID_W-1:0]    halt_id_q, halt_id_d;
    logic [31:0]        retired_q, retired_d;
    logic [15:0]        squashed_q, squashed_d;
    logic               done_q, done_d;

    logic               halt_take;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

    always_comb begin
        stg_d       = stg_q;
        next_id_d   = next_id_q;
        halt_id_d   = halt_id_q;
        retired_d   = retired_q;
        squashed_d  = squashed_q;
        done_d      = done_q;

        // HLT only counts when it actually leaves IF: stalled or squashed
        // HLTs do not halt fetch.
        halt_take   = bus.hlt & stg_q[S_IF].valid & ~bus.stall & ~bus.flush;
        halt_seen_d = halt_seen_q | halt_take;
        if (halt_take && !halt_seen_q) begin
            halt_id_d = stg_q[S_IF].id;
        end

        // IF: allocate the next ID unless fetch has stopped. A flushed IF
        // slot is simply not forwarded to ID, so IDs stay contiguous and a
        // squashed ID is never reused.
        if (bus.stall) begin
            if (stg_q[S_IF].valid) begin
                stg_d[S_IF].stall = sat_inc(stg_q[S_IF].stall);
            end
        end else if (halt_seen_d) begin
            stg_d[S_IF] = BUBBLE;
        end else begin
            stg_d[S_IF] = '{valid: 1'b1, id: next_id_q, stall: '0};
            next_id_d   = (next_id_q == ID_W'(DEPTH - 1)) ? '0 : next_id_q + ID_W'(1);
        end

        // ID: stall beats flush.
        if (bus.stall) begin
            if (stg_q[S_ID].valid) begin
                stg_d[S_ID].stall = sat_inc(stg_q[S_ID].stall);
            end
        end else if (bus.flush) begin
            stg_d[S_ID] = BUBBLE;
        end else begin
            stg_d[S_ID] = stg_q[S_IF];
        end

        // EX: a stall inserts a bubble. Flush does not touch ID->EX because
        // the branch that caused it sits in ID and proceeds.
        stg_d[S_EX]  = bus.stall ? BUBBLE : stg_q[S_ID];
        stg_d[S_MEM] = stg_q[S_EX];
        stg_d[S_WB]  = stg_q[S_MEM];

        if (stg_q[S_WB].valid) begin
            retired_d = retired_q + 32'd1;
        end
        if (bus.flush && !bus.stall && stg_q[S_IF].valid) begin
            squashed_d = squashed_q + 16'd1;
        end
        if (stg_q[S_WB].valid && halt_seen_q && (stg_q[S_WB].id == halt_id_q)) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q       <= '0;
            next_id_q   <= '0;
            halt_seen_q <= 1'b0;
            halt_id_q   <= '0;
            retired_q   <= '0;
            squashed_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            stg_q       <= stg_d;
            next_id_q   <= next_id_d;
            halt_seen_q <= halt_seen_d;
            halt_id_q   <= halt_id_d;
            retired_q   <= retired_d;
            squashed_q  <= squashed_d;
            done_q      <= done_d;
        end
    end

    assign bus.if_valid       = stg_q[S_IF].valid;
    assign bus.id_valid       = stg_q[S_ID].valid;
    assign bus.ex_valid       = stg_q[S_EX].valid;
    assign bus.mem_valid      = stg_q[S_MEM].valid;
    assign bus.wb_valid       = stg_q[S_WB].valid;
    assign bus.if_id          = stg_q[S_IF].id;
    assign bus.id_id          = stg_q[S_ID].id;
    assign bus.ex_id          = stg_q[S_EX].id;
    assign bus.mem_id         = stg_q[S_MEM].id;
    assign bus.wb_id          = stg_q[S_WB].id;
    assign bus.wb_stall_cnt   = stg_q[S_WB].stall;
    assign bus.retired_count  = retired_q;
    assign bus.squashed_count = squashed_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_pipeline_id_tracker.sv
// ---------------------------------------------------------------------------
// tb_pipeline_id_tracker
//   Directed scenarios followed by randomized stall/flush/hlt/rst traffic.
//   The reference model keeps five instruction slots as plain ints, derives
//   IDs from an unbounded fetch count modulo DEPTH, and keeps its counters as
//   wide ints that are truncated only when compared.
// ---------------------------------------------------------------------------
module tb_pipeline_id_tracker;
    localparam int DEPTH   = 72;
    localparam int ID_W    = 7;
    localparam int STALL_W = 4;
    localparam int SMAX    = (1 << STALL_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_id_tracker_if #(.ID_W(ID_W), .STALL_W(STALL_W)) bus();

    pipeline_id_tracker #(.DEPTH(DEPTH), .ID_W(ID_W), .STALL_W(STALL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int id;
        int st;
    } slot_t;

    slot_t   m[5];          // 0=IF 1=ID 2=EX 3=MEM 4=WB
    longint  fetched;       // instructions ever fetched since reset
    bit      m_halt;
    int      m_halt_id;
    longint  m_ret;
    longint  m_sq;
    bit      m_done;

    function automatic slot_t bub();
        slot_t s;
        s.v = 0; s.id = 0; s.st = 0;
        return s;
    endfunction

    function automatic int sat(input int x);
        return (x < SMAX) ? x + 1 : SMAX;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m[i] = bub();
        fetched = 0; m_halt = 0; m_halt_id = 0; m_ret = 0; m_sq = 0; m_done = 0;
    endtask

    task automatic model_step(input bit st, input bit fl, input bit h);
        slot_t n[5];
        bit    hs;
        hs = m_halt || (h && m[0].v && !st && !fl);
        if (m[4].v) m_ret++;
        if (m[4].v && m_halt && m[4].id == m_halt_id) m_done = 1;
        if (fl && !st && m[0].v) m_sq++;
        n[4] = m[3];
        n[3] = m[2];
        if (st) begin
            n[2] = bub();
            n[1] = m[1]; if (n[1].v) n[1].st = sat(n[1].st);
            n[0] = m[0]; if (n[0].v) n[0].st = sat(n[0].st);
        end else begin
            n[2] = m[1];
            n[1] = fl ? bub() : m[0];
            if (hs) n[0] = bub();
            else begin
                n[0].v = 1; n[0].id = int'(fetched % DEPTH); n[0].st = 0;
                fetched++;
            end
        end
        if (!m_halt && hs) m_halt_id = m[0].id;
        m_halt = hs;
        for (int i = 0; i < 5; i++) m[i] = n[i];
    endtask

    task automatic check_all();
        chk("if_valid",  32'(bus.if_valid),  32'(m[0].v));
        chk("id_valid",  32'(bus.id_valid),  32'(m[1].v));
        chk("ex_valid",  32'(bus.ex_valid),  32'(m[2].v));
        chk("mem_valid", 32'(bus.mem_valid), 32'(m[3].v));
        chk("wb_valid",  32'(bus.wb_valid),  32'(m[4].v));
        chk("if_id",     32'(bus.if_id),     m[0].id);
        chk("id_id",     32'(bus.id_id),     m[1].id);
        chk("ex_id",     32'(bus.ex_id),     m[2].id);
        chk("mem_id",    32'(bus.mem_id),    m[3].id);
        chk("wb_id",     32'(bus.wb_id),     m[4].id);
        chk("wb_stall_cnt", 32'(bus.wb_stall_cnt), m[4].st);
        chk("retired_count", bus.retired_count, m_ret[31:0]);
        chk("squashed_count", 32'(bus.squashed_count), {16'd0, m_sq[15:0]});
        chk("done", 32'(bus.done), 32'(m_done));
    endtask

    // One clock: drive at negedge, step model, compare at next negedge.
    task automatic cyc(input bit st, input bit fl, input bit h);
        rst = 1'b0; bus.stall = st; bus.flush = fl; bus.hlt = h;
        model_step(st, fl, h);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input bit st, input bit fl, input bit h);
        rst = 1'b1; bus.stall = st; bus.flush = fl; bus.hlt = h;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    logic [15:0] sq_before;
    bit          prev_wb8;

    initial begin
        rst = 1'b1; bus.stall = 0; bus.flush = 0; bus.hlt = 0;
        @(negedge clk);

        // Reset state, with controls asserted to show rst dominates.
        do_reset(1, 1, 1);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_retired",  bus.retired_count, 32'd0);

        // Free run: if_id 0..9, wb_id 0 at cycle 4, five retired by cycle 9.
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0);
            chk("free_if_id", 32'(bus.if_id), k);
            if (k == 4) begin
                chk("free_wb_valid4", 32'(bus.wb_valid), 32'd1);
                chk("free_wb_id4",    32'(bus.wb_id),    32'd0);
            end
        end
        chk("free_retired9", bus.retired_count, 32'd5);

        // Stall three cycles while ID 2 sits in ID.
        do_reset(0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0);
        chk("stall_pre_id", 32'(bus.id_id), 32'd2);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0);
            chk("stall_hold_id", 32'(bus.id_id), 32'd2);
            chk("stall_hold_if", 32'(bus.if_id), 32'd3);
        end
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0);
            if (bus.wb_valid && bus.wb_id == 2)
                chk("stall_wb_cnt", 32'(bus.wb_stall_cnt), 32'd3);
        end

        // Flush with ID 5 in IF.
        do_reset(0, 0, 0);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0);
        chk("flush_pre_if", 32'(bus.if_id), 32'd5);
        cyc(0, 1, 0);
        chk("flush_id_bubble", 32'(bus.id_valid), 32'd0);
        chk("flush_sq", 32'(bus.squashed_count), 32'd1);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0);

        // Stall and flush together: stall wins.
        sq_before = bus.squashed_count;
        cyc(1, 1, 0);
        chk("stfl_sq", 32'(bus.squashed_count), 32'(sq_before));

        // Run past the ID wrap.
        for (int k = 0; k < 80; k++) cyc(0, 0, 0);

        // HLT at ID 8, then drain and check done timing.
        do_reset(0, 0, 0);
        for (int k = 0; k < 9; k++) cyc(0, 0, 0);
        chk("hlt_pre_if", 32'(bus.if_id), 32'd8);
        cyc(0, 0, 1);
        chk("hlt_no_fetch", 32'(bus.if_valid), 32'd0);
        prev_wb8 = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0);
            if (prev_wb8) chk("hlt_done", 32'(bus.done), 32'd1);
            prev_wb8 = bus.wb_valid && bus.wb_id == 8;
        end
        chk("hlt_done_end", 32'(bus.done), 32'd1);
        do_reset(0, 0, 0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);

        // Randomized traffic with occasional mid-run resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) < 2)
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                cyc(1'($urandom_range(0, 99) < 25),
                    1'($urandom_range(0, 99) < 15),
                    1'($urandom_range(0, 99) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_id_tracker.md
# pipeline_id_tracker

Tags every fetched instruction in the five-stage pipeline with a sequence ID. Carries that ID, its valid bit and its stall count through IF/ID/EX/MEM/WB under the same stall, flush and halt rules as the CPU's pipeline registers. Sits beside the CPU in the Phase-2 testbench, upstream of the verification/debug-print logic, which uses its per-stage valid/ID outputs to index message storage. Also keeps retire and squash counters and flags program completion.

## Interface
- DEPTH, 72: number of distinct IDs; IDs wrap DEPTH-1 -> 0
- ID_W, 7: ID width; must satisfy 2^ID_W >= DEPTH
- STALL_W, 4: per-instruction stall counter width, saturating
- clk  in  1  sole clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  freezes IF and ID, inserts bubble into EX
- flush  in  1  squashes the instruction in IF (taken branch resolved in ID)
- hlt  in  1  instruction currently in IF is HLT
- if_valid, id_valid, ex_valid, mem_valid, wb_valid  out  1 each  stage holds a live instruction
- if_id, id_id, ex_id, mem_id, wb_id  out  ID_W each  sequence ID in that stage
- wb_stall_cnt  out  STALL_W  stall cycles accumulated by the instruction in WB
- retired_count  out  32  instructions that have left WB
- squashed_count  out  16  instructions killed by flush
- done  out  1  sticky; HLT instruction has retired

## Operation
- Reset (rst=1 at posedge): all *_valid=0, all *_id=0, all stall counts=0, next_id=0, halt_seen=0, retired_count=0, squashed_count=0, done=0.
- Next-state rules at each posedge with rst=0. Evaluate in this order; all updates are simultaneous:
  - IF, when !stall: if_valid<=!halt_seen_next; if allocating, if_id<=next_id, next_id<=(next_id==DEPTH-1)?0:next_id+1, if_stall<=0. When stall: IF holds; if_stall increments if if_valid (saturate at 2^STALL_W-1).
  - halt_seen_next = halt_seen | (hlt & if_valid & !stall & !flush). Records which ID is HLT in halt_id. A squashed HLT never halts.
  - ID: if stall, hold and increment id_stall (saturating, only if id_valid). Else if flush, id_valid<=0. Else ID<=IF contents (valid, id, stall count).
  - EX: if stall, EX<=bubble (ex_valid=0). Else EX<=ID. Flush does not affect the ID->EX move; the branch in ID proceeds.
  - MEM<=EX and WB<=MEM unconditionally.
  - retired_count+1 when wb_valid. squashed_count+1 when flush & !stall & if_valid. Both wrap silently.
  - done<=1 when wb_valid & halt_seen & wb_id==halt_id. Only rst clears it.
- stall and flush together: stall wins. Flush is ignored that cycle, nothing is squashed, and the counter is unchanged.
- Bubbles carry id=0 and stall count=0. Consumers must qualify IDs with valid.
- After halt_seen, IF delivers no new instructions. The pipeline drains and wb_valid falls after the last instruction.

## Timing
- First posedge with rst=0: if_valid=1, if_id=0.
- With no stalls, ID k is in IF at cycle c, ID at c+1, EX at c+2, MEM at c+3, WB at c+4. It is counted in retired_count at c+5.
- Each stall cycle adds exactly one cycle of IF/ID residency and one bubble in EX.
- A flush squashes the IF instruction the same cycle. ID shows a bubble the next cycle. The IF slot loads next_id, so IDs stay contiguous; a squashed ID is never reused.
- done rises one cycle after the HLT instruction is valid in WB.
- rst asserted mid-operation clears everything at that edge. No partial drain, and no counter carries over.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Free-run 10 cycles after reset, no stall/flush -> if_id 0..9 consecutive; wb_id=0 with wb_valid at cycle 4; retired_count=5 at cycle 9.
- Stall held 3 cycles while ID 2 is in ID -> ID 2 and 3 hold, three EX bubbles, ID 2 reaches WB with wb_stall_cnt=3.
- Flush with ID 5 in IF -> ID 5 never appears in ID/EX/MEM/WB; ID stage bubble next cycle; squashed_count=1; ID 6 follows ID 4 in WB.
- Stall and flush asserted together -> nothing squashed, squashed_count unchanged, ID and IF hold.
- Run past 72 fetches -> if_id goes 71 -> 0 with no gap.
- hlt with ID 8 in IF -> no ID 9 fetched; done=1 one cycle after wb_id=8 valid; pulse rst mid-run -> all outputs return to reset values at that edge.
